// File: rtl/serial_adder_ctrl.sv
// Bit-serial NBITS-wide adder: one gate-level full adder walked across the
// operands LSB first, with val/rdy handshakes on both sides.

// Single-bit gate-level full adder.
module FullAdder_GL (
  input  logic in0,
  input  logic in1,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = in0 ^ in1 ^ cin;
  assign cout = (in0 & in1) | (cin & (in0 ^ in1));
endmodule

module serial_adder_ctrl #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_a,
  input  logic [NBITS-1:0] in_b,
  input  logic             in_cin,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_cout;
  logic             accept, last;

  FullAdder_GL fa (
    .in0  (a_sr[0]),
    .in1  (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last     = (cnt == CW'(NBITS - 1));
  assign out_sum  = sum_sr;
  assign out_cout = carry;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        out_val = 1'b1;
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result shifters: load on accept, one bit per CALC cycle.
  // Sum bits enter at the MSB so the LSB lands at bit 0 after NBITS shifts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= in_a;
      b_sr   <= in_b;
      sum_sr <= '0;
      carry  <= in_cin;
      cnt    <= '0;
    end else if (state == CALC) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= NBITS'({fa_sum, sum_sr} >> 1);
      carry  <= fa_cout;
      cnt    <= cnt + CW'(1);
    end
  end
endmodule
